// File: rtl/crc32_pkg.sv
`default_nettype none
// ============================================================================
// crc32_pkg : CRC-32 defaults, types and slicing-by-4 table generator
// Rev 1.0
// ============================================================================
package crc32_pkg;

  typedef logic [31:0]        crc_t;
  typedef logic [255:0][31:0] tab_t;

  localparam crc_t C_POLY   = 32'hEDB88320;
  localparam crc_t C_INIT   = 32'hFFFFFFFF;
  localparam crc_t C_XOROUT = 32'hFFFFFFFF;

  // Slice k advances a byte that sits k positions ahead of the accumulator head.
  function automatic tab_t gen_tab(input crc_t poly, input int slice);
    tab_t t0;
    tab_t tk;
    crc_t c;
    for (int b = 0; b < 256; b++) begin
      c = crc_t'(b);
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
      end
      t0[b] = c;
    end
    tk = t0;
    for (int s = 1; s <= slice; s++) begin
      for (int b = 0; b < 256; b++) begin
        tk[b] = (tk[b] >> 8) ^ t0[tk[b][7:0]];
      end
    end
    return tk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_slice_lut.sv
`default_nettype none
// ============================================================================
// crc32_slice_lut : combinational 256x32 CRC slice table ROM
// Rev 1.0
// ============================================================================
module crc32_slice_lut
  import crc32_pkg::*;
#(
  parameter crc_t POLY  = C_POLY,
  parameter int   SLICE = 0
) (
  input  logic [7:0]  addr,
  output logic [31:0] rdata
);

  localparam tab_t C_TAB = gen_tab(POLY, SLICE);

  assign rdata = C_TAB[addr];

endmodule
`default_nettype wire

// File: rtl/crc32_slice4_engine.sv
`default_nettype none
// ============================================================================
// crc32_slice4_engine : reflected CRC-32 over 32-bit beats, slicing-by-4
// Rev 1.0
// ============================================================================
module crc32_slice4_engine
  import crc32_pkg::*;
#(
  parameter crc_t POLY   = C_POLY,
  parameter crc_t INIT   = C_INIT,
  parameter crc_t XOROUT = C_XOROUT,
  parameter int   LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  input  logic [1:0]       s_nbytes,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_crc,
  output logic [LEN_W-1:0] m_len
);

  logic             s1_valid_q, s1_valid_d;
  crc_t             s1_data_q, s1_data_d;
  logic             s1_last_q, s1_last_d;
  logic [1:0]       s1_nb_q, s1_nb_d;
  crc_t             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  crc_t             m_crc_q, m_crc_d;
  logic [LEN_W-1:0] m_len_q, m_len_d;

  logic             advance;
  logic             accept;
  logic [3:0]       byte_en;
  crc_t             data_masked;
  crc_t             x;
  crc_t             shifted;
  crc_t             acc_next;
  logic [2:0]       n_bytes;
  logic [LEN_W:0]   cnt_sum;
  logic [LEN_W-1:0] cnt_sat;
  crc_t             lut_rdata [4];

  // A waiting last beat only blocks when the result register is still owned.
  always_comb begin
    advance = s1_valid_q && !(s1_last_q && m_valid_q && !m_ready);
    s_ready = !rst && (!s1_valid_q || advance);
    accept  = s_valid && s_ready;
  end

  always_comb begin
    byte_en = 4'b1111;
    shifted = '0;
    case (s1_nb_q)
      2'd0:    begin byte_en = 4'b0001; shifted = acc_q >> 8;  end
      2'd1:    begin byte_en = 4'b0011; shifted = acc_q >> 16; end
      2'd2:    begin byte_en = 4'b0111; shifted = acc_q >> 24; end
      default: begin byte_en = 4'b1111; shifted = '0;          end
    endcase
    data_masked = '0;
    for (int i = 0; i < 4; i++) begin
      data_masked[8*i +: 8] = byte_en[i] ? s1_data_q[8*i +: 8] : 8'h00;
    end
    x = acc_q ^ data_masked;
  end

  // Slice k consumes byte (n-1-k) of x; slices with k >= n are gated off.
  for (genvar k = 0; k < 4; k++) begin : g_slice
    logic [1:0] byte_sel;
    assign byte_sel = s1_nb_q - 2'(k);
    crc32_slice_lut #(
      .POLY  (POLY),
      .SLICE (k)
    ) u_lut (
      .addr  (x[{byte_sel, 3'b000} +: 8]),
      .rdata (lut_rdata[k])
    );
  end

  always_comb begin
    acc_next = shifted;
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) begin
        acc_next = acc_next ^ lut_rdata[k];
      end
    end
  end

  always_comb begin
    n_bytes = {1'b0, s1_nb_q} + 3'd1;
    cnt_sum = {1'b0, cnt_q} + {{(LEN_W-2){1'b0}}, n_bytes};
    cnt_sat = cnt_sum[LEN_W] ? {LEN_W{1'b1}} : cnt_sum[LEN_W-1:0];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_last_d  = s1_last_q;
    s1_nb_d    = s1_nb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q && !m_ready;
    m_crc_d    = m_crc_q;
    m_len_d    = m_len_q;

    if (advance) begin
      s1_valid_d = 1'b0;
      if (s1_last_q) begin
        acc_d     = INIT;
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_crc_d   = acc_next ^ XOROUT;
        m_len_d   = cnt_sat;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_sat;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = s_data;
      s1_last_d  = s_last;
      s1_nb_d    = s_last ? s_nbytes : 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_nb_q    <= 2'd3;
      acc_q      <= INIT;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_crc_q    <= '0;
      m_len_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_last_q  <= s1_last_d;
      s1_nb_q    <= s1_nb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_crc_q    <= m_crc_d;
      m_len_q    <= m_len_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_len   = m_len_q;

endmodule
`default_nettype wire
